sqm_seq_engine: RTL and testbench
=================================

Name: sqm_seq_engine

Overview:
- Sequential, handshaked version of the combinational square-and-multiply unit.
- Computes Y = A^B mod 2^WA using left-to-right binary exponentiation, with one multiply per clock.
- Accepts operand pairs from a stimulus or producer side and returns results to a consumer or checker side.
- Intended as the multi-cycle, area-reduced replacement inside the 32-bit ALU math-function datapath.

Parameters:
- WA, 8, width of base A and result Y; all arithmetic is truncated to WA bits (mod 2^WA).
- WB, 4, width of exponent B; sets the number of square steps per operation.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 resets immediately; release is synchronous to clk).
- in_valid  input  1  producer presents A, B this cycle.
- in_ready  output  1  engine can accept an operand pair.
- A  input  WA  base.
- B  input  WB  exponent.
- out_valid  output  1  Y holds a completed result.
- out_ready  input  1  consumer accepts Y this cycle.
- Y  output  WA  result A^B mod 2^WA.
- busy  output  1  operation in progress (states SQ or MUL).
- done_count  output  8  count of results handed off; wraps 255->0.

Behaviour:
- Reset values (reset=0):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, Y=0, done_count=0.
  - Internal acc=1, a_reg=0, b_reg=0, idx=WB-1.
- States: IDLE, SQ, MUL, DONE. Encoding lives in the package.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a clock edge: a_reg<=A, b_reg<=B, acc<=1, idx<=WB-1, next state SQ.
  - A and B are sampled only on that edge; later changes to A and B are ignored.
- SQ:
  - acc<=(acc*acc)[WA-1:0].
  - If b_reg[idx]=1, go to MUL.
  - Else if idx==0, go to DONE.
  - Else idx<=idx-1 and stay in SQ.
- MUL:
  - acc<=(acc*a_reg)[WA-1:0].
  - If idx==0, go to DONE; else idx<=idx-1 and go to SQ.
- DONE:
  - out_valid=1, Y=acc.
  - Y is held stable while out_ready=0; backpressure is unbounded.
  - On out_ready=1: next state IDLE, done_count increments.
- Latency from accept edge to the first cycle of out_valid=1 is exactly WB+popcount(B) cycles.
  - Minimum WB (B=0); maximum 2*WB (B all ones).
- Throughput: at most one result per WB+popcount(B)+2 cycles.
  - in_ready is high only in IDLE, so there is no accept in the DONE->IDLE handoff cycle.
- Y is registered and driven from acc.
  - Y is only meaningful while out_valid=1.
  - Outside DONE, Y holds its last value; it is 0 after reset.
- Boundary cases:
  - B=0 gives Y=1 for any A, including 0^0=1.
  - A=0 with B>0 gives Y=0.
  - Overflow is silently truncated.
- in_valid asserted outside IDLE is ignored; no queuing, and the producer must hold until in_ready.
- out_ready asserted outside DONE has no effect.
- Reset asserted mid-operation (SQ, MUL or DONE):
  - Immediate return to reset values.
  - The partial result is discarded and done_count is cleared.
- Multiplier: single WA x WA product with the low WA bits kept.
  - The operand mux is acc/acc in SQ and acc/a_reg in MUL; one shared multiplier.

Decomposition:
- Package sqm_pkg holds:
  - the state enum typedef (IDLE, SQ, MUL, DONE);
  - default WA and WB localparams;
  - the helper function popcount for latency checks in the bench.
- One natural sub-module: sqm_mul_trunc, a combinational WA x WA multiplier returning the low WA bits.
- The FSM, operand registers, index counter and done_count stay in the top module.

Test Plan:
- A=3, B=5, out_ready=1 -> Y=0xF3 (243); out_valid rises 6 cycles after accept; done_count=1.
- A=2, B=9 -> Y=0x00 (512 truncated), latency 6. A=255, B=15 -> Y=0xFF, latency 8.
- A=0, B=0 -> Y=0x01, latency 4. A=7, B=0 -> Y=0x01. A=0, B=3 -> Y=0x00.
- Backpressure: A=7, B=2 with out_ready=0 for 10 cycles:
  - out_valid and Y=0x31 held stable throughout, in_ready=0;
  - on out_ready=1 -> IDLE next cycle, done_count increments once;
  - in_valid pulses during busy are ignored.
- Reset mid-operation: accept A=3, B=15, drive reset=0 on the 3rd busy cycle (asynchronous, mid-cycle):
  - outputs go to reset values immediately;
  - after release, A=5, B=2 -> Y=0x19 with done_count=1.
- Regression: 50 random A/B pairs checked against (A**B) mod 256 and against latency WB+popcount(B) -> zero errors, done_count=50.

Source files
------------

// File: rtl/sqm_pkg.sv
// rtl/sqm_pkg.sv - shared types, default widths and helpers for the square-and-multiply engine
package sqm_pkg;

  localparam int SQM_WA = 8;
  localparam int SQM_WB = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SQ   = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } sqm_state_e;

  // Number of set bits; the engine spends one extra MUL cycle per set exponent bit.
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sqm_mul_trunc.sv
// rtl/sqm_mul_trunc.sv - combinational WA x WA multiplier keeping the low WA bits
module sqm_mul_trunc #(
  parameter int WA = 8
) (
  input  logic [WA-1:0] i_a,
  input  logic [WA-1:0] i_b,
  output logic [WA-1:0] o_p
);

  assign o_p = i_a * i_b;

endmodule

// File: rtl/sqm_seq_engine.sv
// rtl/sqm_seq_engine.sv - handshaked left-to-right A^B mod 2^WA, one multiply per clock
module sqm_seq_engine
  import sqm_pkg::*;
#(
  parameter int WA = SQM_WA,
  parameter int WB = SQM_WB
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WA-1:0] A,
  input  logic [WB-1:0] B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WA-1:0] Y,
  output logic          busy,
  output logic [7:0]    done_count
);

  localparam int IW = (WB > 1) ? $clog2(WB) : 1;

  sqm_state_e    r_state;
  logic [WA-1:0] r_acc;
  logic [WA-1:0] r_a;
  logic [WB-1:0] r_b;
  logic [IW-1:0] r_idx;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_busy;
  logic [WA-1:0] r_y;
  logic [7:0]    r_done_count;

  logic [WA-1:0] w_mul_b;
  logic [WA-1:0] w_prod;

  // One shared multiplier: squares in SQ, multiplies by the base in MUL.
  assign w_mul_b = (r_state == ST_MUL) ? r_a : r_acc;

  sqm_mul_trunc #(
    .WA (WA)
  ) u_mul (
    .i_a (r_acc),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_acc        <= WA'(1);
      r_a          <= '0;
      r_b          <= '0;
      r_idx        <= IW'(WB - 1);
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_y          <= '0;
      r_done_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= A;
            r_b        <= B;
            r_acc      <= WA'(1);
            r_idx      <= IW'(WB - 1);
            r_state    <= ST_SQ;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_SQ: begin
          r_acc <= w_prod;
          if (r_b[r_idx]) begin
            r_state <= ST_MUL;
          end else if (r_idx == '0) begin
            r_state     <= ST_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_y         <= w_prod;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        ST_MUL: begin
          r_acc <= w_prod;
          if (r_idx == '0) begin
            r_state     <= ST_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_y         <= w_prod;
          end else begin
            r_idx   <= r_idx - 1'b1;
            r_state <= ST_SQ;
          end
        end
        ST_DONE: begin
          // Y stays frozen until the consumer takes it; no accept in the handoff cycle.
          if (out_ready) begin
            r_state      <= ST_IDLE;
            r_out_valid  <= 1'b0;
            r_in_ready   <= 1'b1;
            r_done_count <= r_done_count + 8'd1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign Y          = r_y;
  assign done_count = r_done_count;

endmodule

// File: tb/tb_sqm_seq_engine.sv
// tb/tb_sqm_seq_engine.sv - randomized self-checking bench for sqm_seq_engine
module tb_sqm_seq_engine;

  localparam int WA = 8;
  localparam int WB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [WA-1:0] A = '0;
  logic [WB-1:0] B = '0;
  logic          in_ready;
  logic          out_valid;
  logic          busy;
  logic [WA-1:0] Y;
  logic [7:0]    done_count;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 idle, 1 computing, 2 result waiting.
  int            m_phase;
  int            m_cnt;
  int            m_dc;
  logic [WA-1:0] m_y;
  logic [WA-1:0] m_pend;

  sqm_seq_engine #(.WA(WA), .WB(WB)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Y          (Y),
    .busy       (busy),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  function automatic logic [WA-1:0] ref_pow(input logic [WA-1:0] a, input logic [WB-1:0] b);
    int unsigned r;
    r = 1;
    for (int i = 0; i < int'(b); i++) r = (r * int'(a)) % 256;
    return WA'(r);
  endfunction

  task automatic check(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, got, got, want, want, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_dc    <= 0;
      m_y     <= '0;
      m_pend  <= '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_pend  <= ref_pow(A, B);
          m_cnt   <= WB + $countones(B);
          m_phase <= 1;
        end
        1: if (m_cnt == 1) begin
          m_phase <= 2;
          m_y     <= m_pend;
        end else begin
          m_cnt <= m_cnt - 1;
        end
        default: if (out_ready) begin
          m_phase <= 0;
          m_dc    <= (m_dc + 1) % 256;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", int'(in_ready), int'(m_phase == 0));
      check("out_valid", int'(out_valid), int'(m_phase == 2));
      check("busy", int'(busy), int'(m_phase == 1));
      check("Y", int'(Y), int'(m_y));
      check("done_count", int'(done_count), m_dc);
    end
  end

  task automatic do_op(input logic [WA-1:0] a, input logic [WB-1:0] b, input int hold,
                       output logic [WA-1:0] y, output int lat);
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = WA'($urandom);
    B = WB'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid) in_valid = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    check("op_completes", int'(out_valid), 1);
    y = Y;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WA-1:0] y;
    int lat;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_Y", int'(Y), 0);
    check("rst_done_count", int'(done_count), 0);
    reset = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    do_op(8'd3, 4'd5, 0, y, lat);
    check("3^5_y", int'(y), 243);
    check("3^5_lat", lat, 6);
    check("3^5_dc", int'(done_count), 1);
    do_op(8'd2, 4'd9, 0, y, lat);
    check("2^9_y", int'(y), 0);
    check("2^9_lat", lat, 6);
    do_op(8'd255, 4'd15, 0, y, lat);
    check("255^15_y", int'(y), 255);
    check("255^15_lat", lat, 8);
    do_op(8'd0, 4'd0, 0, y, lat);
    check("0^0_y", int'(y), 1);
    check("0^0_lat", lat, 4);
    do_op(8'd7, 4'd0, 1, y, lat);
    check("7^0_y", int'(y), 1);
    do_op(8'd0, 4'd3, 2, y, lat);
    check("0^3_y", int'(y), 0);
    check("0^3_lat", lat, 6);

    do_op(8'd7, 4'd2, 10, y, lat);
    check("bp_y", int'(y), 8'h31);
    check("bp_lat", lat, 5);
    check("bp_in_ready", int'(in_ready), 1);
    check("bp_dc", int'(done_count), 7);

    A = 8'd3;
    B = 4'd15;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_Y", int'(Y), 0);
    check("mid_rst_dc", int'(done_count), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    do_op(8'd5, 4'd2, 0, y, lat);
    check("5^2_y", int'(y), 8'h19);
    check("5^2_lat", lat, 5);
    check("5^2_dc", int'(done_count), 1);

    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 50; k++) begin
      logic [WA-1:0] ra;
      logic [WB-1:0] rb;
      ra = WA'($urandom);
      rb = WB'($urandom);
      if (k % 7 == 0) ra = '0;
      do_op(ra, rb, int'($urandom_range(0, 3)), y, lat);
      check("rand_y", int'(y), int'(ref_pow(ra, rb)));
      check("rand_lat", lat, WB + $countones(rb));
    end
    check("rand_dc", int'(done_count), 50);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
